// File: rtl/xnor2_gate.sv
// Purpose : two-input XNOR primitive with a registered observability side-path.
// Latency : y is combinational (0 cycles); y_q, pulses and counters update 1 cycle after sampling.
// Backpr. : none -- no handshake, the side-path samples every rising clk edge.
//
// Ports:
//   clk      - clock for the monitoring path only; y does not depend on it
//   rst      - synchronous active-high reset of the monitoring path (y unaffected)
//   a, b     - operands
//   y        - ~(a ^ b), combinational
//   y_q      - y registered
//   y_rise   - one-cycle pulse when y sampled 1 while y_q was 0
//   y_fall   - one-cycle pulse when y sampled 0 while y_q was 1
//   eq_run   - consecutive edges with y==1, saturating, cleared when y==0
//   eq_total - total edges with y==1 since reset, saturating
module xnor2_gate #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a,
   input  logic             b,
   output logic             y,
   output logic             y_q,
   output logic             y_rise,
   output logic             y_fall,
   output logic [CNT_W-1:0] eq_run,
   output logic [CNT_W-1:0] eq_total
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             y_q_d;
   logic             y_rise_q, y_rise_d;
   logic             y_fall_q, y_fall_d;
   logic [CNT_W-1:0] eq_run_q, eq_run_d;
   logic [CNT_W-1:0] eq_total_q, eq_total_d;

   // Counters stick at all-ones so a long equal run never reads as a short one.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
      if (x == CNT_MAX) begin
         return x;
      end
      return x + 1'b1;
   endfunction

   // Pure gate path: no dependence on clk or rst.
   assign y = ~(a ^ b);

   always_comb begin
      y_q_d      = y;
      y_rise_d   = y & ~y_q;
      y_fall_d   = ~y & y_q;
      eq_run_d   = '0;
      eq_total_d = eq_total_q;
      if (y) begin
         eq_run_d   = sat_inc(eq_run_q);
         eq_total_d = sat_inc(eq_total_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y_q        <= 1'b0;
         y_rise_q   <= 1'b0;
         y_fall_q   <= 1'b0;
         eq_run_q   <= '0;
         eq_total_q <= '0;
      end else begin
         y_q        <= y_q_d;
         y_rise_q   <= y_rise_d;
         y_fall_q   <= y_fall_d;
         eq_run_q   <= eq_run_d;
         eq_total_q <= eq_total_d;
      end
   end

   assign y_rise   = y_rise_q;
   assign y_fall   = y_fall_q;
   assign eq_run   = eq_run_q;
   assign eq_total = eq_total_q;

endmodule

// File: tb/tb_xnor2_gate.sv
`timescale 1ns/1ps
// Bench for xnor2_gate: an 8-bit-counter instance and a 2-bit-counter instance
// share the same stimulus so saturation is reached quickly on the narrow one.
module tb_xnor2_gate;

   logic       clk = 1'b0;
   logic       clk_run = 1'b0;
   logic       rst, a, b;

   logic       y8, yq8, rise8, fall8;
   logic [7:0] run8, tot8;
   logic       y2, yq2, rise2, fall2;
   logic [1:0] run2, tot2;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 if (clk_run) clk = ~clk;

   xnor2_gate #(.CNT_W(8)) u_dut8 (
      .clk(clk), .rst(rst), .a(a), .b(b),
      .y(y8), .y_q(yq8), .y_rise(rise8), .y_fall(fall8),
      .eq_run(run8), .eq_total(tot8)
   );

   xnor2_gate #(.CNT_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .a(a), .b(b),
      .y(y2), .y_q(yq2), .y_rise(rise2), .y_fall(fall2),
      .eq_run(run2), .eq_total(tot2)
   );

   // 4-state compare so X/Z on an output is reported as a mismatch.
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive inputs, take one rising edge, settle 1 ns past it.
   task automatic step(input logic ai, input logic bi, input logic ri);
      a = ai; b = bi; rst = ri;
      @(posedge clk);
      #1;
   endtask

   task automatic chk8(input string tag, input logic yq, input logic r, input logic f,
                       input logic [7:0] er, input logic [7:0] et);
      check_eq({tag, " y_q"},      {31'd0, yq8},   {31'd0, yq});
      check_eq({tag, " y_rise"},   {31'd0, rise8}, {31'd0, r});
      check_eq({tag, " y_fall"},   {31'd0, fall8}, {31'd0, f});
      check_eq({tag, " eq_run"},   {24'd0, run8},  {24'd0, er});
      check_eq({tag, " eq_total"}, {24'd0, tot8},  {24'd0, et});
   endtask

   task automatic chk2(input string tag, input logic [1:0] er, input logic [1:0] et);
      check_eq({tag, " w2 eq_run"},   {30'd0, run2}, {30'd0, er});
      check_eq({tag, " w2 eq_total"}, {30'd0, tot2}, {30'd0, et});
   endtask

   logic [3:0] tt_y   = 4'b1001;     // y for ab = 11,10,01,00 (bit index = {a,b})
   logic [1:0] sat_run[6] = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};

   initial begin
      logic       m_y, m_yq, m_rise, m_fall;
      int         m_tot8, m_tot2, m_run8;
      logic [1:0] ab;

      rst = 1'b1; a = 1'b0; b = 1'b0;

      // Truth table with the clock stopped and reset held.
      for (int i = 0; i < 4; i++) begin
         ab = i[1:0];
         a = ab[1]; b = ab[0];
         #10;
         check_eq($sformatf("tt a=%0d b=%0d", a, b), {31'd0, y8}, {31'd0, tt_y[i]});
         check_eq($sformatf("tt w2 a=%0d b=%0d", a, b), {31'd0, y2}, {31'd0, tt_y[i]});
      end

      clk_run = 1'b1;
      step(1'b0, 1'b0, 1'b1);
      chk8("reset", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      chk2("reset", 2'd0, 2'd0);

      // Equal run of three edges.
      step(1'b0, 1'b0, 1'b0); chk8("run e1", 1'b1, 1'b1, 1'b0, 8'd1, 8'd1);
      step(1'b0, 1'b0, 1'b0); chk8("run e2", 1'b1, 1'b0, 1'b0, 8'd2, 8'd2);
      step(1'b0, 1'b0, 1'b0); chk8("run e3", 1'b1, 1'b0, 1'b0, 8'd3, 8'd3);
      chk2("run e3", 2'd3, 2'd3);

      // Run break, then two equal edges.
      step(1'b1, 1'b0, 1'b0); chk8("break",  1'b0, 1'b0, 1'b1, 8'd0, 8'd3);
      chk2("break", 2'd0, 2'd3);
      step(1'b1, 1'b1, 1'b0); chk8("again1", 1'b1, 1'b1, 1'b0, 8'd1, 8'd4);
      chk2("again1", 2'd1, 2'd3);
      step(1'b1, 1'b1, 1'b0); chk8("again2", 1'b1, 1'b0, 1'b0, 8'd2, 8'd5);

      // Mid-run reset with y=1: registered outputs clear, y stays high.
      step(1'b1, 1'b1, 1'b1); chk8("midrst", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      chk2("midrst", 2'd0, 2'd0);
      check_eq("midrst y", {31'd0, y8}, 32'd1);
      step(1'b1, 1'b1, 1'b0); chk8("release", 1'b1, 1'b1, 1'b0, 8'd1, 8'd1);

      // Six more equal edges: 2-bit counters stick at 3, 8-bit keep counting.
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0, 1'b0);
         chk2($sformatf("sat e%0d", i), sat_run[i], sat_run[i]);
      end
      chk8("sat end", 1'b1, 1'b0, 1'b0, 8'd7, 8'd7);

      // Random stimulus against a reference model.
      step(1'b0, 1'b1, 1'b1);
      m_yq = 1'b0; m_tot8 = 0; m_tot2 = 0; m_run8 = 0;
      for (int i = 0; i < 1000; i++) begin
         a = 1'($urandom); b = 1'($urandom); rst = 1'b0;
         m_y = (a == b);
         #1;
         check_eq("rnd y", {31'd0, y8}, {31'd0, m_y});
         @(posedge clk);
         #1;
         m_rise = m_y & ~m_yq;
         m_fall = ~m_y & m_yq;
         m_yq   = m_y;
         if (m_y) begin
            m_tot8 = (m_tot8 < 255) ? m_tot8 + 1 : 255;
            m_tot2 = (m_tot2 < 3)   ? m_tot2 + 1 : 3;
            m_run8 = (m_run8 < 255) ? m_run8 + 1 : 255;
         end else begin
            m_run8 = 0;
         end
         check_eq("rnd y_q",    {31'd0, yq8},   {31'd0, m_yq});
         check_eq("rnd y_rise", {31'd0, rise8}, {31'd0, m_rise});
         check_eq("rnd y_fall", {31'd0, fall8}, {31'd0, m_fall});
         check_eq("rnd excl",   {31'd0, rise8 & fall8}, 32'd0);
         check_eq("rnd run8",   {24'd0, run8}, m_run8);
         check_eq("rnd tot8",   {24'd0, tot8}, m_tot8);
         check_eq("rnd tot2",   {30'd0, tot2}, m_tot2);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
